// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
// obstacle_spawner: paces small/big cactus launches with an LFSR-randomised gap
// Revision: 1.0
// ============================================================================
module obstacle_spawner #(
  parameter int          MIN_GAP   = 120,
  parameter logic [7:0]  GAP_MASK  = 8'hFF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       tick,
  input  logic       finish_s,
  input  logic       finish_b,
  output logic       start_s,
  output logic       start_b,
  output logic       busy,
  output logic [7:0] spawn_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_LAUNCH = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [8:0] C_MIN_GAP = 9'(MIN_GAP);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic [8:0]  r_gap;
  logic [8:0]  w_gap_nxt;
  logic [8:0]  w_reload;
  logic        w_pick_s;
  logic        w_pick_b;
  logic        w_start_s_nxt;
  logic        w_start_b_nxt;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_reload  = C_MIN_GAP + {1'b0, r_lfsr[7:0] & GAP_MASK};

  // Preferred kind from lfsr[8]; fall back to the other renderer when it is free.
  assign w_pick_b = r_lfsr[8] ? finish_b : (!finish_s && finish_b);
  assign w_pick_s = r_lfsr[8] ? (!finish_b && finish_s) : finish_s;

  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap;
    w_start_s_nxt = 1'b0;
    w_start_b_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_gap_nxt   = w_reload;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (r_gap <= 9'd1) begin
            w_gap_nxt   = 9'd0;
            w_state_nxt = S_LAUNCH;
          end else begin
            w_gap_nxt = r_gap - 9'd1;
          end
        end
      end
      S_LAUNCH, S_HOLD: begin
        if (w_pick_s || w_pick_b) begin
          w_start_s_nxt = w_pick_s;
          w_start_b_nxt = w_pick_b;
          w_gap_nxt     = w_reload;
          w_state_nxt   = S_GAP;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Pause overrides everything, including a pending launch.
    if (!run) begin
      w_state_nxt   = S_IDLE;
      w_gap_nxt     = 9'd0;
      w_start_s_nxt = 1'b0;
      w_start_b_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_gap       <= 9'd0;
      start_s     <= 1'b0;
      start_b     <= 1'b0;
      busy        <= 1'b0;
      spawn_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
      r_gap   <= w_gap_nxt;
      start_s <= w_start_s_nxt;
      start_b <= w_start_b_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      if (w_start_s_nxt || w_start_b_nxt) begin
        spawn_count <= spawn_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter MIN_GAP, default 120, the minimum number of scroll ticks between spawns.
REQ-002 SHALL have parameter GAP_MASK, default 8'hFF, the mask applied to the LFSR for the random extra gap.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, the LFSR value after reset; must be nonzero.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit: game running; 0 means paused or game over.
REQ-007 SHALL have port tick, input, 1 bit: one-clk pulse per one-column scroll step (the same event that advances the cactus renderers).
REQ-008 SHALL have port finish_s, input, 1 bit: the small-cactus renderer is idle and off screen.
REQ-009 SHALL have port finish_b, input, 1 bit: the big-cactus renderer is idle and off screen.
REQ-010 SHALL have port start_s, output, 1 bit: one-clk launch pulse to the small-cactus renderer.
REQ-011 SHALL have port start_b, output, 1 bit: one-clk launch pulse to the big-cactus renderer.
REQ-012 SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.
REQ-013 SHALL have port spawn_count, output, 8 bits: number of launches, wrapping.

Function
REQ-014 SHALL implement a 16-bit Fibonacci LFSR that is free-running every clk, shifting left, with new bit[0] = b15^b13^b12^b10.
REQ-015 SHALL implement a 4-state FSM: IDLE, GAP, LAUNCH, HOLD. All outputs SHALL be registered.
REQ-016 IDLE: when run=1, SHALL load gap_cnt = MIN_GAP + (lfsr[7:0] & GAP_MASK) (9-bit, no overflow) and go to GAP.
REQ-017 GAP: SHALL decrement gap_cnt on each clk where tick=1; on the tick that takes gap_cnt from 1 to 0, SHALL go to LAUNCH next cycle; with tick=0, gap_cnt holds.
REQ-018 LAUNCH: SHALL select the preferred kind by lfsr[8] (0 = small, 1 = big).
  - If the preferred renderer's finish=1: pulse its start.
  - Else, if the other renderer's finish=1: pulse the other start.
  - Else: go to HOLD with no pulse.
REQ-019 On a pulse, the FSM SHALL reload gap_cnt (as REQ-016) and return to GAP in the same edge; start_s/start_b SHALL be high for exactly one clk, never simultaneously.
REQ-020 HOLD: SHALL re-evaluate every clk with the REQ-018 rule using the current lfsr[8]; it SHALL leave only by issuing a pulse or by run=0.
REQ-021 spawn_count SHALL increment by 1 on every clk a start pulse is issued; 255 SHALL wrap to 0.
REQ-022 If run=0 in any state: next state SHALL be IDLE, no start pulse that cycle, gap_cnt cleared, spawn_count held.
REQ-023 Simultaneous run=0 and a LAUNCH pulse condition: run=0 SHALL win (no pulse).
REQ-024 tick SHALL be ignored outside GAP.
REQ-025 A tick arriving in the cycle of a gap reload SHALL NOT decrement the new gap.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL set state=IDLE, lfsr=LFSR_SEED, gap_cnt=0, start_s=0, start_b=0, busy=0, spawn_count=0.
REQ-027 Reset SHALL take priority over run and tick.
REQ-028 Reset mid-GAP or mid-HOLD SHALL abort with no pulse.

Verification
REQ-029 Check reset values: hold rst 3 clks with run=1, tick=1 -> all outputs 0 and the LFSR equals 16'hACE1 on the first post-reset edge.
REQ-030 Check first-spawn timing: MIN_GAP=4, GAP_MASK=0, finish_s=finish_b=1, run=1, tick every 3rd clk -> exactly one start pulse 1 clk after the 4th tick; the pulse is on start_s or start_b per lfsr[8]; spawn_count=1.
REQ-031 Check HOLD: MIN_GAP=2, GAP_MASK=0, finish_s=finish_b=0 -> FSM stays in HOLD with no pulses for 50 clks; raise finish_b -> start_b pulses the next clk, once.
REQ-032 Check fallback: in LAUNCH with preferred finish=0 and other finish=1 -> the other start pulses; no HOLD entry.
REQ-033 Check pause and reset abort: drop run mid-GAP -> busy=0 next clk, no pulse, spawn_count unchanged; restart run -> a fresh full gap. Assert rst while in HOLD -> no pulse.
REQ-034 Check count wrap: force 256 launches with MIN_GAP=1, GAP_MASK=0, tick=1 continuously -> spawn_count returns to 0; start_s and start_b are never high together.
